// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer sharing one combinational 8-bit ALU among NUM_REQ requesters.
// One operation is in flight at a time; the result is returned on the granted requester's response channel.
//
// state  | meaning
// S_IDLE | waiting for a request; grants combinationally by round-robin
// S_EXEC | operation registers drive the ALU; result captured at the edge
// S_RESP | rsp_valid[gnt] high until the granted requester raises rsp_ready
module alu_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [3*NUM_REQ-1:0]   req_op,
    input  logic [8*NUM_REQ-1:0]   req_a,
    input  logic [8*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [7:0]             rsp_data,
    output logic                   rsp_err,
    output logic [7:0]             alu_op,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    input  logic [7:0]             alu_y,
    output logic                   busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        r_gnt;
    logic [2:0]           r_op;
    logic [7:0]           r_a;
    logic [7:0]           r_b;
    logic [7:0]           r_rsp_data;
    logic                 r_rsp_err;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [PW-1:0]        w_idx;
    logic [PW-1:0]        w_pick;
    logic                 w_any;
    logic                 w_grant;

    // Walk from the farthest candidate back to ptr+1 so the nearest valid requester wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_ptr;
        w_idx  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = PW'((int'(r_ptr) + k) % NUM_REQ);
            if (req_valid[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    assign w_grant = (r_state == S_IDLE) && w_any;

    // Gated by rst so no grant is advertised while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst && w_grant) begin
            req_ready[w_pick] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready[r_gnt]) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr       <= PW'(NUM_REQ - 1);
            r_gnt       <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= '0;
        end else begin
            if (w_grant) begin
                r_gnt <= w_pick;
                r_ptr <= w_pick;
                r_op  <= req_op[3*int'(w_pick) +: 3];
                r_a   <= req_a[8*int'(w_pick) +: 8];
                r_b   <= req_b[8*int'(w_pick) +: 8];
            end
            if (r_state == S_EXEC) begin
                if (r_op <= 3'd5) begin
                    r_rsp_data <= alu_y;
                    r_rsp_err  <= 1'b0;
                end else begin
                    r_rsp_data <= 8'h00;
                    r_rsp_err  <= 1'b1;
                end
            end
            r_rsp_valid <= '0;
            if (w_state_nxt == S_RESP) begin
                r_rsp_valid[r_gnt] <= 1'b1;
            end
        end
    end

    assign alu_op    = {5'b00000, r_op};
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign rsp_valid = r_rsp_valid;
    assign busy      = (r_state != S_IDLE);

endmodule
